// File: rtl/punc_controller.sv
//==============================================================================
// Module      : punc_controller
// Description : Control FSM for the PUnC LC3 processor. It decodes the state
//               and the instruction register into the datapath control word.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module punc_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic        nzp_true,

    output logic        pc_ld,
    output logic        pc_clr,
    output logic        pc_inc,
    output logic [1:0]  pc_sel,

    output logic        ir_ld,
    output logic        ir_clr,

    output logic        mem_rd,
    output logic        mem_wr,
    output logic [1:0]  mem_r_addr_sel,
    output logic [1:0]  mem_w_addr_sel,

    output logic [1:0]  rf_w_data_sel,
    output logic        rf_w_addr_sel,
    output logic        rf_w_wr,
    output logic        rf_r0_addr_sel,
    output logic        rf_r0_rd,
    output logic        rf_r1_rd,

    output logic        temp_ld,
    output logic        nzp_ld,
    output logic        nzp_clr,

    output logic [1:0]  alu_sel,
    output logic        alu_first_val_sel,

    output logic        halted
);

    typedef enum logic [2:0] {
        c_ST_INIT   = 3'd0,
        c_ST_FETCH  = 3'd1,
        c_ST_DECODE = 3'd2,
        c_ST_EXEC   = 3'd3,
        c_ST_EXEC2  = 3'd4,
        c_ST_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] c_OP_BR   = 4'b0000;
    localparam logic [3:0] c_OP_ADD  = 4'b0001;
    localparam logic [3:0] c_OP_LD   = 4'b0010;
    localparam logic [3:0] c_OP_ST   = 4'b0011;
    localparam logic [3:0] c_OP_JSR  = 4'b0100;
    localparam logic [3:0] c_OP_AND  = 4'b0101;
    localparam logic [3:0] c_OP_LDR  = 4'b0110;
    localparam logic [3:0] c_OP_STR  = 4'b0111;
    localparam logic [3:0] c_OP_NOT  = 4'b1001;
    localparam logic [3:0] c_OP_LDI  = 4'b1010;
    localparam logic [3:0] c_OP_STI  = 4'b1011;
    localparam logic [3:0] c_OP_JMP  = 4'b1100;
    localparam logic [3:0] c_OP_LEA  = 4'b1110;
    localparam logic [3:0] c_OP_HALT = 4'b1111;

    // Select encodings shared with the datapath
    localparam logic [1:0] c_PC_OFF9     = 2'd0;
    localparam logic [1:0] c_PC_OFF11    = 2'd1;
    localparam logic [1:0] c_PC_R1       = 2'd2;
    localparam logic [1:0] c_MRA_PC      = 2'd0;
    localparam logic [1:0] c_MRA_OFF9    = 2'd1;
    localparam logic [1:0] c_MRA_TEMP    = 2'd2;
    localparam logic [1:0] c_MRA_R1OFF6  = 2'd3;
    localparam logic [1:0] c_MWA_OFF9    = 2'd0;
    localparam logic [1:0] c_MWA_TEMP    = 2'd1;
    localparam logic [1:0] c_MWA_R1OFF6  = 2'd2;
    localparam logic [1:0] c_RFD_ALU     = 2'd0;
    localparam logic [1:0] c_RFD_OFF9    = 2'd1;
    localparam logic [1:0] c_RFD_MEM     = 2'd2;
    localparam logic [1:0] c_RFD_PC      = 2'd3;
    localparam logic       c_RFA_R7      = 1'b0;
    localparam logic       c_RFA_DR      = 1'b1;
    localparam logic       c_R0A_DR      = 1'b0;
    localparam logic       c_R0A_SR2     = 1'b1;
    localparam logic [1:0] c_ALU_ADD     = 2'd1;
    localparam logic [1:0] c_ALU_AND     = 2'd2;
    localparam logic [1:0] c_ALU_NOT     = 2'd3;

    state_t     r_state;
    logic [3:0] w_opcode;
    logic       w_unused;

    assign w_opcode = ir[15:12];
    // Offsets and register fields are consumed directly by the datapath
    assign w_unused = ^{ir[10:6], ir[4:0]};

    //--------------------------------------------------------------------------
    // State register and next-state logic
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_INIT;
        end else begin
            case (r_state)
                c_ST_INIT:   r_state <= c_ST_FETCH;
                c_ST_FETCH:  r_state <= c_ST_DECODE;
                c_ST_DECODE: r_state <= (w_opcode == c_OP_HALT) ? c_ST_HALT : c_ST_EXEC;
                c_ST_EXEC:   r_state <= (w_opcode == c_OP_LDI || w_opcode == c_OP_STI)
                                        ? c_ST_EXEC2 : c_ST_FETCH;
                c_ST_EXEC2:  r_state <= c_ST_FETCH;
                c_ST_HALT:   r_state <= c_ST_HALT;
                default:     r_state <= c_ST_INIT;
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Control word decode
    //--------------------------------------------------------------------------
    always_comb begin
        pc_ld             = 1'b0;
        pc_clr            = 1'b0;
        pc_inc            = 1'b0;
        pc_sel            = 2'd0;
        ir_ld             = 1'b0;
        ir_clr            = 1'b0;
        mem_rd            = 1'b0;
        mem_wr            = 1'b0;
        mem_r_addr_sel    = 2'd0;
        mem_w_addr_sel    = 2'd0;
        rf_w_data_sel     = 2'd0;
        rf_w_addr_sel     = 1'b0;
        rf_w_wr           = 1'b0;
        rf_r0_addr_sel    = 1'b0;
        rf_r0_rd          = 1'b0;
        rf_r1_rd          = 1'b0;
        temp_ld           = 1'b0;
        nzp_ld            = 1'b0;
        nzp_clr           = 1'b0;
        alu_sel           = 2'd0;
        alu_first_val_sel = 1'b0;
        halted            = 1'b0;

        case (r_state)
            c_ST_INIT: begin
                pc_clr  = 1'b1;
                ir_clr  = 1'b1;
                nzp_clr = 1'b1;
            end

            c_ST_FETCH: begin
                mem_r_addr_sel = c_MRA_PC;
                mem_rd         = 1'b1;
                ir_ld          = 1'b1;
                pc_inc         = 1'b1;
            end

            c_ST_EXEC: begin
                case (w_opcode)
                    c_OP_ADD, c_OP_AND: begin
                        rf_r0_addr_sel    = c_R0A_SR2;
                        rf_r0_rd          = 1'b1;
                        rf_r1_rd          = 1'b1;
                        alu_first_val_sel = ir[5];
                        alu_sel           = (w_opcode == c_OP_ADD) ? c_ALU_ADD : c_ALU_AND;
                        rf_w_data_sel     = c_RFD_ALU;
                        rf_w_addr_sel     = c_RFA_DR;
                        rf_w_wr           = 1'b1;
                        nzp_ld            = 1'b1;
                    end
                    c_OP_NOT: begin
                        rf_r1_rd      = 1'b1;
                        alu_sel       = c_ALU_NOT;
                        rf_w_data_sel = c_RFD_ALU;
                        rf_w_addr_sel = c_RFA_DR;
                        rf_w_wr       = 1'b1;
                        nzp_ld        = 1'b1;
                    end
                    c_OP_BR: begin
                        // nzp_true is already 0 when ir[11:9] is 000
                        if (nzp_true) begin
                            pc_sel = c_PC_OFF9;
                            pc_ld  = 1'b1;
                        end
                    end
                    c_OP_JMP: begin
                        rf_r1_rd = 1'b1;
                        pc_sel   = c_PC_R1;
                        pc_ld    = 1'b1;
                    end
                    c_OP_JSR: begin
                        // Read of the base register and link write share one edge,
                        // so JSRR R7 jumps to the old R7.
                        rf_w_addr_sel = c_RFA_R7;
                        rf_w_data_sel = c_RFD_PC;
                        rf_w_wr       = 1'b1;
                        pc_ld         = 1'b1;
                        if (ir[11]) begin
                            pc_sel = c_PC_OFF11;
                        end else begin
                            pc_sel   = c_PC_R1;
                            rf_r1_rd = 1'b1;
                        end
                    end
                    c_OP_LD, c_OP_LDR: begin
                        mem_r_addr_sel = (w_opcode == c_OP_LD) ? c_MRA_OFF9 : c_MRA_R1OFF6;
                        rf_r1_rd       = (w_opcode == c_OP_LDR);
                        mem_rd         = 1'b1;
                        rf_w_data_sel  = c_RFD_MEM;
                        rf_w_addr_sel  = c_RFA_DR;
                        rf_w_wr        = 1'b1;
                        nzp_ld         = 1'b1;
                    end
                    c_OP_LEA: begin
                        rf_w_data_sel = c_RFD_OFF9;
                        rf_w_addr_sel = c_RFA_DR;
                        rf_w_wr       = 1'b1;
                        nzp_ld        = 1'b1;
                    end
                    c_OP_ST, c_OP_STR: begin
                        rf_r0_addr_sel = c_R0A_DR;
                        rf_r0_rd       = 1'b1;
                        mem_w_addr_sel = (w_opcode == c_OP_ST) ? c_MWA_OFF9 : c_MWA_R1OFF6;
                        rf_r1_rd       = (w_opcode == c_OP_STR);
                        mem_wr         = 1'b1;
                    end
                    c_OP_LDI, c_OP_STI: begin
                        // First access fetches the pointer into temp
                        mem_r_addr_sel = c_MRA_OFF9;
                        mem_rd         = 1'b1;
                        temp_ld        = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end

            c_ST_EXEC2: begin
                if (w_opcode == c_OP_LDI) begin
                    mem_r_addr_sel = c_MRA_TEMP;
                    mem_rd         = 1'b1;
                    rf_w_data_sel  = c_RFD_MEM;
                    rf_w_addr_sel  = c_RFA_DR;
                    rf_w_wr        = 1'b1;
                    nzp_ld         = 1'b1;
                end else if (w_opcode == c_OP_STI) begin
                    mem_w_addr_sel = c_MWA_TEMP;
                    rf_r0_addr_sel = c_R0A_DR;
                    rf_r0_rd       = 1'b1;
                    mem_wr         = 1'b1;
                end
            end

            c_ST_HALT: begin
                halted = 1'b1;
            end

            default: begin
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_punc_controller.sv
//==============================================================================
// Module      : tb_punc_controller
// Description : Scoreboard bench for punc_controller with an instruction-level
//               reference model and randomized instruction streams.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_punc_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] ir = 16'h0000;
    logic        nzp_true = 1'b0;

    logic       pc_ld, pc_clr, pc_inc;
    logic [1:0] pc_sel;
    logic       ir_ld, ir_clr, mem_rd, mem_wr;
    logic [1:0] mem_r_addr_sel, mem_w_addr_sel, rf_w_data_sel;
    logic       rf_w_addr_sel, rf_w_wr, rf_r0_addr_sel, rf_r0_rd, rf_r1_rd;
    logic       temp_ld, nzp_ld, nzp_clr;
    logic [1:0] alu_sel;
    logic       alu_first_val_sel, halted;

    punc_controller dut (
        .clk(clk), .rst(rst), .ir(ir), .nzp_true(nzp_true),
        .pc_ld(pc_ld), .pc_clr(pc_clr), .pc_inc(pc_inc), .pc_sel(pc_sel),
        .ir_ld(ir_ld), .ir_clr(ir_clr),
        .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_r_addr_sel(mem_r_addr_sel), .mem_w_addr_sel(mem_w_addr_sel),
        .rf_w_data_sel(rf_w_data_sel), .rf_w_addr_sel(rf_w_addr_sel),
        .rf_w_wr(rf_w_wr), .rf_r0_addr_sel(rf_r0_addr_sel),
        .rf_r0_rd(rf_r0_rd), .rf_r1_rd(rf_r1_rd),
        .temp_ld(temp_ld), .nzp_ld(nzp_ld), .nzp_clr(nzp_clr),
        .alu_sel(alu_sel), .alu_first_val_sel(alu_first_val_sel),
        .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_ld, pc_clr, pc_inc;
        logic [1:0] pc_sel;
        logic       ir_ld, ir_clr, mem_rd, mem_wr;
        logic [1:0] mem_r_addr_sel, mem_w_addr_sel, rf_w_data_sel;
        logic       rf_w_addr_sel, rf_w_wr, rf_r0_addr_sel, rf_r0_rd, rf_r1_rd;
        logic       temp_ld, nzp_ld, nzp_clr;
        logic [1:0] alu_sel;
        logic       alu_first_val_sel, halted;
    } ctrl_t;

    localparam int PH_INIT = 0, PH_FETCH = 1, PH_DECODE = 2, PH_EXEC = 3,
                   PH_EXEC2 = 4, PH_HALT = 5;

    ctrl_t exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    ctrl_t act;

    // Reference: control word required in a given instruction phase
    function automatic ctrl_t model(int ph, logic [15:0] ins, logic nz);
        ctrl_t      c = '0;
        logic [3:0] op = ins[15:12];
        case (ph)
            PH_INIT:  begin c.pc_clr = 1; c.ir_clr = 1; c.nzp_clr = 1; end
            PH_FETCH: begin c.mem_rd = 1; c.ir_ld = 1; c.pc_inc = 1; end
            PH_HALT:  c.halted = 1;
            PH_EXEC: begin
                if (op == 4'h1 || op == 4'h5) begin
                    c.rf_r0_addr_sel = 1; c.rf_r0_rd = 1; c.rf_r1_rd = 1;
                    c.alu_first_val_sel = ins[5];
                    c.alu_sel = (op == 4'h1) ? 2'd1 : 2'd2;
                end
                if (op == 4'h9) begin c.rf_r1_rd = 1; c.alu_sel = 2'd3; end
                if (op == 4'h1 || op == 4'h5 || op == 4'h9) begin
                    c.rf_w_addr_sel = 1; c.rf_w_wr = 1; c.nzp_ld = 1;
                end
                if (op == 4'h0 && nz && ins[11:9] != 3'b000) c.pc_ld = 1;
                if (op == 4'hC) begin c.rf_r1_rd = 1; c.pc_sel = 2'd2; c.pc_ld = 1; end
                if (op == 4'h4) begin
                    c.rf_w_data_sel = 2'd3; c.rf_w_wr = 1; c.pc_ld = 1;
                    c.pc_sel = ins[11] ? 2'd1 : 2'd2;
                    c.rf_r1_rd = !ins[11];
                end
                if (op == 4'h2 || op == 4'h6) begin
                    c.mem_r_addr_sel = (op == 4'h2) ? 2'd1 : 2'd3;
                    c.rf_r1_rd = (op == 4'h6);
                    c.mem_rd = 1; c.rf_w_data_sel = 2'd2;
                    c.rf_w_addr_sel = 1; c.rf_w_wr = 1; c.nzp_ld = 1;
                end
                if (op == 4'hE) begin
                    c.rf_w_data_sel = 2'd1; c.rf_w_addr_sel = 1; c.rf_w_wr = 1; c.nzp_ld = 1;
                end
                if (op == 4'h3 || op == 4'h7) begin
                    c.rf_r0_rd = 1; c.mem_wr = 1;
                    c.mem_w_addr_sel = (op == 4'h3) ? 2'd0 : 2'd2;
                    c.rf_r1_rd = (op == 4'h7);
                end
                if (op == 4'hA || op == 4'hB) begin
                    c.mem_r_addr_sel = 2'd1; c.mem_rd = 1; c.temp_ld = 1;
                end
            end
            PH_EXEC2: begin
                if (op == 4'hA) begin
                    c.mem_r_addr_sel = 2'd2; c.mem_rd = 1; c.rf_w_data_sel = 2'd2;
                    c.rf_w_addr_sel = 1; c.rf_w_wr = 1; c.nzp_ld = 1;
                end
                if (op == 4'hB) begin
                    c.mem_w_addr_sel = 2'd1; c.rf_r0_rd = 1; c.mem_wr = 1;
                end
            end
            default: ;
        endcase
        return c;
    endfunction

    // Monitor: pops one expected word per cycle and compares mid-cycle
    always @(negedge clk) begin
        act = '{pc_ld, pc_clr, pc_inc, pc_sel, ir_ld, ir_clr, mem_rd, mem_wr,
                mem_r_addr_sel, mem_w_addr_sel, rf_w_data_sel, rf_w_addr_sel,
                rf_w_wr, rf_r0_addr_sel, rf_r0_rd, rf_r1_rd, temp_ld, nzp_ld,
                nzp_clr, alu_sel, alu_first_val_sel, halted};
        if (exp_q.size() > 0) begin
            ctrl_t e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s @%0t: ctrl got %h expected %h", n, $time, act, e);
            end
        end
        checks++;
        if (pc_inc && pc_ld) begin
            errors++;
            $display("FAIL inv_pc @%0t: pc_inc=%b pc_ld=%b both set", $time, pc_inc, pc_ld);
        end
        checks++;
        if (mem_wr && rf_w_wr) begin
            errors++;
            $display("FAIL inv_wr @%0t: mem_wr=%b rf_w_wr=%b both set", $time, mem_wr, rf_w_wr);
        end
    end

    task automatic push(int ph, logic [15:0] ins, logic nz, string nm);
        exp_q.push_back(model(ph, ins, nz));
        name_q.push_back(nm);
    endtask

    task automatic step(int ph, logic [15:0] ins, logic nz, string nm);
        @(posedge clk);
        #1;
        ir = ins;
        nzp_true = nz;
        push(ph, ins, nz, nm);
    endtask

    task automatic finish_reset();
        repeat (2) begin
            @(posedge clk);
            #1;
            push(PH_INIT, ir, 1'b0, "reset_hold");
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        push(PH_INIT, ir, 1'b0, "init_after_release");
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(PH_INIT, ir, 1'b0, "reset_assert");
        finish_reset();
    endtask

    task automatic run_instr(logic [15:0] ins, logic nz, string nm);
        step(PH_FETCH, ins, nz, {nm, "_fetch"});
        step(PH_DECODE, ins, nz, {nm, "_decode"});
        if (ins[15:12] == 4'hF) begin
            repeat (12) step(PH_HALT, ins, nz, {nm, "_halt"});
        end else begin
            step(PH_EXEC, ins, nz, {nm, "_exec"});
            if (ins[15:12] == 4'hA || ins[15:12] == 4'hB)
                step(PH_EXEC2, ins, nz, {nm, "_exec2"});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] ins;
        logic        nz;

        do_reset();
        run_instr(16'h1261, 1'b0, "add_imm");
        run_instr(16'h0402, 1'b1, "brz_taken");
        run_instr(16'h0402, 1'b0, "brz_not_taken");
        run_instr(16'hA203, 1'b0, "ldi");
        run_instr(16'h41C0, 1'b0, "jsrr_r7");
        run_instr(16'h5000, 1'b0, "and_reg");
        run_instr(16'hF025, 1'b0, "halt");
        do_reset();

        // STI aborted by reset in its second execute cycle
        step(PH_FETCH, 16'hB203, 1'b0, "sti_fetch");
        step(PH_DECODE, 16'hB203, 1'b0, "sti_decode");
        step(PH_EXEC, 16'hB203, 1'b0, "sti_exec");
        @(posedge clk);
        #1;
        checks++;
        if (mem_wr !== 1'b1) begin
            errors++;
            $display("FAIL sti_exec2_wr: mem_wr got %b expected 1", mem_wr);
        end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (mem_wr !== 1'b0 || pc_clr !== 1'b1) begin
            errors++;
            $display("FAIL sti_abort: mem_wr=%b pc_clr=%b expected 0 and 1", mem_wr, pc_clr);
        end
        push(PH_INIT, ir, 1'b0, "sti_abort_init");
        finish_reset();

        for (int i = 0; i < 300; i++) begin
            ins = 16'($urandom);
            nz  = 1'($urandom_range(0, 1)) & (|ins[11:9]);
            run_instr(ins, nz, "rand");
            if (ins[15:12] == 4'hF) do_reset();
        end

        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected words left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/punc_controller.md
Name: punc_controller

Overview:
- Control FSM for the PUnC LC3 processor. It drives every select, load and strobe input of the PUnC datapath.
- Inputs are the datapath's instruction register and branch-condition flag; outputs are the per-cycle control word.
- Sequence per instruction: fetch, decode, execute (one extra execute cycle for LDI/STI), with a terminal HALT state.

Parameters:
- none (LC3 opcode map and datapath select encodings are fixed; listed under Behaviour)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- ir  input  16  instruction register contents from the datapath
- nzp_true  input  1  (ir[11]&n)|(ir[10]&z)|(ir[9]&p), from the datapath
- pc_ld, pc_clr, pc_inc  output  1 each  PC load / clear / increment
- pc_sel  output  2  0: PC+sext(ir[8:0]); 1: PC+sext(ir[10:0]); 2: RF read port 1 data
- ir_ld, ir_clr  output  1 each  IR load from memory read data / IR clear
- mem_rd, mem_wr  output  1 each  memory read qualifier / write enable
- mem_r_addr_sel  output  2  0: PC; 1: PC+off9; 2: temp; 3: R1data+off6
- mem_w_addr_sel  output  2  0: PC+off9; 1: temp; 2: R1data+off6
- rf_w_data_sel  output  2  0: ALU; 1: PC+off9; 2: memory read data; 3: PC
- rf_w_addr_sel  output  1  0: R7; 1: ir[11:9]
- rf_w_wr  output  1  register file write enable
- rf_r0_addr_sel  output  1  0: ir[11:9]; 1: ir[2:0]
- rf_r0_rd, rf_r1_rd  output  1 each  read-port-in-use qualifiers; port 1 address is always ir[8:6]
- temp_ld  output  1  temp register loads memory read data
- nzp_ld, nzp_clr  output  1 each  condition-code load (from RF write data) / clear
- alu_sel  output  2  0: PassA; 1: ADD; 2: AND; 3: NOT of R1 data
- alu_first_val_sel  output  1  0: R0 data; 1: sext(ir[4:0])
- halted  output  1  high while in HALT

Behaviour:
- States: INIT, FETCH, DECODE, EXEC, EXEC2, HALT.
- Outputs are a combinational decode of state and ir. Every output is 0 unless stated for the current state.
- Reset: while rst=0, state is forced to INIT asynchronously. Outputs then read pc_clr=ir_clr=nzp_clr=1, all others 0, halted=0. Reset during any state, including EXEC2 or HALT, aborts immediately; no partial write is re-issued.
- INIT:
  - Asserts pc_clr, ir_clr, nzp_clr.
  - Next state is FETCH.
- FETCH:
  - mem_r_addr_sel=0, mem_rd=1, ir_ld=1, pc_inc=1.
  - Next state is DECODE.
- DECODE:
  - No strobes.
  - Next state is HALT if ir[15:12]=1111, otherwise EXEC.
- EXEC, per opcode ir[15:12]; next state is FETCH unless noted:
  - ADD 0001 / AND 0101: rf_r0_addr_sel=1, rf_r0_rd=1, rf_r1_rd=1, alu_first_val_sel=ir[5], alu_sel=1 (ADD) or 2 (AND), rf_w_data_sel=0, rf_w_addr_sel=1, rf_w_wr=1, nzp_ld=1.
  - NOT 1001: rf_r1_rd=1, alu_sel=3, rf_w_data_sel=0, rf_w_addr_sel=1, rf_w_wr=1, nzp_ld=1.
  - BR 0000: if nzp_true, pc_sel=0 and pc_ld=1. BR with ir[11:9]=000 never branches.
  - JMP/RET 1100: rf_r1_rd=1, pc_sel=2, pc_ld=1.
  - JSR/JSRR 0100: rf_w_addr_sel=0, rf_w_data_sel=3, rf_w_wr=1, pc_ld=1. pc_sel=1 if ir[11]=1; else pc_sel=2 with rf_r1_rd=1.
    - R7 receives the already-incremented PC.
    - JSRR R7 jumps to the old R7, because the read and the write occur on the same edge.
  - LD 0010: mem_r_addr_sel=1, mem_rd=1, rf_w_data_sel=2, rf_w_addr_sel=1, rf_w_wr=1, nzp_ld=1.
  - LDR 0110: as LD, but mem_r_addr_sel=3 and rf_r1_rd=1.
  - LEA 1110: rf_w_data_sel=1, rf_w_addr_sel=1, rf_w_wr=1, nzp_ld=1.
  - ST 0011: rf_r0_addr_sel=0, rf_r0_rd=1, mem_w_addr_sel=0, mem_wr=1.
  - STR 0111: as ST, but mem_w_addr_sel=2 and rf_r1_rd=1.
  - LDI 1010 / STI 1011: mem_r_addr_sel=1, mem_rd=1, temp_ld=1. Next state is EXEC2.
  - RTI 1000 / reserved 1101: no strobes (NOP).
- EXEC2:
  - LDI: mem_r_addr_sel=2, mem_rd=1, rf_w_data_sel=2, rf_w_addr_sel=1, rf_w_wr=1, nzp_ld=1.
  - STI: mem_w_addr_sel=1, rf_r0_addr_sel=0, rf_r0_rd=1, mem_wr=1.
  - Next state is FETCH.
- HALT:
  - halted=1, all strobes 0.
  - Remains in HALT until reset.
- Latency: 3 cycles per instruction; LDI/STI take 4.
- Invariants:
  - pc_inc and pc_ld are never asserted in the same cycle.
  - mem_wr and rf_w_wr are never asserted in the same cycle.

Test Plan:
- Reset: hold rst=0 for 3 cycles, release -> INIT outputs (pc_clr=ir_clr=nzp_clr=1) while low; exactly one INIT cycle after release, then FETCH with ir_ld=pc_inc=mem_rd=1.
- ADD: ir=0x1261 (ADD R1,R1,#1) -> EXEC asserts alu_sel=1, alu_first_val_sel=1, rf_w_addr_sel=1, rf_w_wr=1, nzp_ld=1; FETCH follows 3 cycles after the previous FETCH.
- BR: ir=0x0402 (BRz +2) -> with nzp_true=1, EXEC has pc_ld=1 and pc_sel=0; with nzp_true=0, pc_ld=0.
- LDI: ir=0xA203 -> EXEC has temp_ld=1 and mem_r_addr_sel=1; EXEC2 has mem_r_addr_sel=2, rf_w_wr=1, nzp_ld=1; 4-cycle instruction.
- JSRR R7: ir=0x41C0 -> EXEC has pc_sel=2, rf_r1_rd=1, rf_w_addr_sel=0, rf_w_data_sel=3, rf_w_wr=1, pc_ld=1.
- HALT, then reset: ir=0xF025 -> halted=1 from the cycle after DECODE, all strobes 0 for 10+ cycles; rst=0 in EXEC2 of an STI -> mem_wr drops to 0 immediately and state is INIT.
